pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl_pkg.sv | 19 +
 rtl/pc_increment.sv | 9 +
 rtl/pc_fetch_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared core definitions for the fetch-stage PC controller: FSM states,
// default reset vector and target alignment.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MISS  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Instructions are word aligned, so any loaded target drops its low two bits
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_increment.sv
// Sequential-PC adder: produces PC+4 with 32-bit wraparound.
module pc_increment (
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: owns PCF, talks to the instruction cache and
// holds a redirect target while an outstanding cache request drains.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallD,
    input  logic        RedirectE,
    input  logic [31:0] PCTargetE,
    input  logic        ICacheReady,
    output logic        ICacheReq,
    output logic [31:0] ICacheAddr,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        FetchValid,
    output logic        FetchStall
);

    fetch_state_e state, state_next;
    logic [31:0]  pcf, pcf_next;
    logic [31:0]  pending, pending_next;
    logic [31:0]  pc_plus4;

    pc_increment u_pc_increment (
        .pc       (pcf),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pcf     <= RESET_VECTOR;
            pending <= RESET_VECTOR;
        end else begin
            state   <= state_next;
            pcf     <= pcf_next;
            pending <= pending_next;
        end
    end

    // The request stays on the old PC during DRAIN; the redirect only lands
    // once that request has returned, so a late reply cannot be misattributed.
    always_comb begin
        state_next   = state;
        pcf_next     = pcf;
        pending_next = pending;
        ICacheReq    = 1'b0;
        FetchValid   = 1'b0;
        FetchStall   = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH, MISS: begin
                ICacheReq = 1'b1;
                if (ICacheReady) begin
                    FetchValid = ~RedirectE;
                    state_next = FETCH;
                    if (RedirectE)
                        pcf_next = align_target(PCTargetE);
                    else if (!StallD)
                        pcf_next = pc_plus4;
                end else begin
                    FetchStall = 1'b1;
                    if (RedirectE) begin
                        pending_next = align_target(PCTargetE);
                        state_next   = DRAIN;
                    end else begin
                        state_next   = MISS;
                    end
                end
            end
            DRAIN: begin
                ICacheReq  = 1'b1;
                FetchStall = 1'b1;
                if (ICacheReady) begin
                    state_next = FETCH;
                    pcf_next   = RedirectE ? align_target(PCTargetE) : pending;
                end else if (RedirectE) begin
                    pending_next = align_target(PCTargetE);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign PCF        = pcf;
    assign ICacheAddr = pcf;
    assign PCPlus4F   = pc_plus4;

endmodule
